// File: rtl/bp_throttle_source.sv
// Producer-side rate regulator: paces a traffic source into the queue using the
// monitor's level/congestion/backpressure feedback. Optional macro: BP_WATCHDOG_EN.
module bp_throttle_source #(
    parameter int unsigned DATA_W         = 8,
    parameter int unsigned LEVEL_W        = 8,
    parameter int unsigned HI_WM          = 192,
    parameter int unsigned LO_WM          = 64,
    parameter int unsigned THROTTLE_DIV   = 4,
    parameter int unsigned RECOVER_CYCLES = 16,
    parameter int unsigned CNT_W          = 16,
    parameter int unsigned WD_CYCLES      = 256
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               src_valid,
    output logic               src_ready,
    input  logic [DATA_W-1:0]  src_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  out_data,
    input  logic [LEVEL_W-1:0] queue_level,
    input  logic               congestion,
    input  logic               backpressure,
    output logic [1:0]         state,
    output logic [CNT_W-1:0]   sent_count,
    output logic [CNT_W-1:0]   stall_count,
    output logic               wd_timeout
);

    localparam int unsigned DIV_W = $clog2(THROTTLE_DIV);
    localparam int unsigned REC_W = $clog2(RECOVER_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_THROTTLE = 2'd1,
        ST_PAUSE    = 2'd2,
        ST_RECOVER  = 2'd3
    } state_e;

    state_e              state_q, state_d;
    logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;
    logic [REC_W-1:0]    rec_cnt_q, rec_cnt_d;
    logic                out_valid_q, out_valid_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;
    logic [CNT_W-1:0]    sent_q, sent_d;
    logic [CNT_W-1:0]    stall_q, stall_d;
    logic                wd_q, wd_d;
    logic                permit;
    logic                load;
    logic                drain;
    logic                level_hi;
    logic                level_lo;

    assign level_hi = (queue_level >= LEVEL_W'(HI_WM));
    assign level_lo = (queue_level <  LEVEL_W'(LO_WM));

    // Issue-slot gate derived only from registered state
    always_comb begin
        permit = 1'b0;
        case (state_q)
            ST_RUN:      permit = 1'b1;
            ST_THROTTLE: permit = (div_cnt_q == '0);
            ST_PAUSE:    permit = 1'b0;
            ST_RECOVER:  permit = ~div_cnt_q[0];
            default:     permit = 1'b0;
        endcase
    end

    assign src_ready = permit && (!out_valid_q || out_ready);
    assign load      = src_valid && src_ready;
    assign drain     = out_valid_q && out_ready;

    // Rate FSM next-state and its pacing counters
    always_comb begin
        state_d   = state_q;
        div_cnt_d = div_cnt_q;
        rec_cnt_d = rec_cnt_q;
        if (backpressure) begin
            state_d = ST_PAUSE;
        end else begin
            case (state_q)
                ST_PAUSE:    state_d = ST_THROTTLE;
                ST_RUN:      if (congestion || level_hi) state_d = ST_THROTTLE;
                ST_THROTTLE: if (!congestion && level_lo) state_d = ST_RECOVER;
                ST_RECOVER: begin
                    if (congestion || level_hi)
                        state_d = ST_THROTTLE;
                    else if (rec_cnt_q == REC_W'(RECOVER_CYCLES - 1))
                        state_d = ST_RUN;
                end
                default:     state_d = ST_RUN;
            endcase
        end

        if (state_d != state_q) begin
            div_cnt_d = '0;
        end else if (state_q == ST_THROTTLE) begin
            div_cnt_d = (div_cnt_q == DIV_W'(THROTTLE_DIV - 1)) ? '0 : div_cnt_q + DIV_W'(1);
        end else if (state_q == ST_RECOVER) begin
            div_cnt_d = div_cnt_q + DIV_W'(1);
        end

        if (state_d == ST_RECOVER && state_q != ST_RECOVER)
            rec_cnt_d = '0;
        else if (state_q == ST_RECOVER && state_d == ST_RECOVER)
            rec_cnt_d = rec_cnt_q + REC_W'(1);
    end

    // Output holding register and saturating telemetry
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        sent_d      = sent_q;
        stall_d     = stall_q;
        if (load) begin
            out_valid_d = 1'b1;
            out_data_d  = src_data;
        end else if (drain) begin
            out_valid_d = 1'b0;
        end
        if (drain && (sent_q != '1))
            sent_d = sent_q + CNT_W'(1);
        if (src_valid && !src_ready && (stall_q != '1))
            stall_d = stall_q + CNT_W'(1);
    end

`ifdef BP_WATCHDOG_EN
    localparam int unsigned WD_W = $clog2(WD_CYCLES + 1);

    logic [WD_W-1:0] pause_cnt_q, pause_cnt_d;

    // Pause-length watchdog; saturates at the limit, flag is sticky
    always_comb begin
        pause_cnt_d = pause_cnt_q;
        wd_d        = wd_q;
        if (state_d == ST_PAUSE) begin
            if (state_q != ST_PAUSE)
                pause_cnt_d = '0;
            else if (pause_cnt_q != WD_W'(WD_CYCLES - 1))
                pause_cnt_d = pause_cnt_q + WD_W'(1);
            if (pause_cnt_d == WD_W'(WD_CYCLES - 1))
                wd_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            pause_cnt_q <= '0;
        else
            pause_cnt_q <= pause_cnt_d;
    end
`else
    // No watchdog: the flag holds its reset value of 0
    always_comb begin
        wd_d = wd_q & (WD_CYCLES == 0);
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_RUN;
            div_cnt_q   <= '0;
            rec_cnt_q   <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            sent_q      <= '0;
            stall_q     <= '0;
            wd_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_cnt_q   <= div_cnt_d;
            rec_cnt_q   <= rec_cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            sent_q      <= sent_d;
            stall_q     <= stall_d;
            wd_q        <= wd_d;
        end
    end

    assign state       = state_q;
    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign sent_count  = sent_q;
    assign stall_count = stall_q;
    assign wd_timeout  = wd_q;

endmodule
